dcache_way_replacer: RTL and testbench
======================================

// Module: dcache_way_replacer
// PURPOSE
//  Victim-way selector for the 32-set x 8-way data cache. Tracks per-set way occupancy
//  and a 7-bit tree pseudo-LRU. Combinationally proposes the refill way for the set
//  addressed by idx. Sits beside the dcache FSM, which latches rway_o into `way` at miss start.
// PARAMETERS
//  NSET   32  number of sets (power of 2)
//  NWAY   8   ways per set (power of 2; tree has NWAY-1 node bits)
//  IDX_W  5   log2(NSET)
//  WAY_W  3   log2(NWAY)
// PORTS
//  clock    in   1      single clock, all state updates on rising edge
//  reset    in   1      asynchronous, active-low; clears all state immediately
//  idx      in   IDX_W  set index being looked up / updated
//  way      in   WAY_W  way being updated (hit way or refill way)
//  access   in   1      pulse: mark (idx,way) occupied and most-recently-used
//  invalid  in   1      pulse: mark (idx,way) unoccupied (line being evicted)
//  rway_o   out  WAY_W  proposed victim way for set idx
// BEHAVIOUR
//  State per set s: occ[s][NWAY-1:0] occupancy vector; plru[s][NWAY-2:0] tree bits.
//  Reset (reset==0, async): all occ=0, all plru=0 -> rway_o==0 for every idx.
//  Tree: heap ordering, node 0 = root, children of n are 2n+1 / 2n+2; leaves = ways 0..7 in order.
//   Node bit 0 -> victim in lower half of its subtree; 1 -> upper half.
//  rway_o (purely combinational from idx and current state, no latency):
//   if occ[idx] != all-ones: lowest-indexed way with occ bit 0;
//   else: walk tree from root following node bits to a leaf.
//  access=1 at posedge: occ[idx][way]<=1; every node on root->way path set to point AWAY
//   from way (bit<=1 if way in lower half of that node, else 0). Other sets untouched.
//  invalid=1 at posedge (access=0): occ[idx][way]<=0; plru unchanged.
//  access and invalid both 1: access wins, invalid ignored.
//  Neither asserted: hold all state.
//  Updates visible on rway_o the cycle after the edge (same idx).
//  idx/way out of range impossible by width; no wrap handling needed.
//  Reset mid-operation: state cleared instantly, regardless of access/invalid; no pending update survives.
// STRUCTURE
//  Shared package: NSET, NWAY, IDX_W, WAY_W constants, PLRU_W = NWAY-1.
//  One sub-module: dff_en #(WIDTH, RESET_VAL) - async active-low reset, enabled register;
//   instantiate once per set for occ and once per set for plru.
//  Victim encoder (priority find-first-zero + tree walk) and path-update logic as functions.
// TESTING
//  1 Reset, sweep idx 0..31 -> rway_o==0 everywhere.
//  2 idx=3: access ways 0..7 one per cycle -> rway_o after each = 1,2,..,7, then 0 (PLRU).
//  3 Continue idx=3: access way 0 -> rway_o==4; access way 4 -> rway_o==2.
//  4 idx=3 invalid way=6 -> next cycle rway_o==6; access way 6 -> back to PLRU victim 2;
//    idx=4 throughout untouched -> rway_o==0.
//  5 idx=3 access=1 & invalid=1 way=5 simultaneously -> occ kept, way 5 made MRU; rway_o==2.
//  6 Drop reset low asynchronously between edges while access=1 -> rway_o==0 immediately,
//    still 0 for all idx after reset release.

Source files
------------

// File: rtl/dcache_way_replacer_pkg.sv
// Shared geometry constants and victim-selection helpers for the dcache way replacer.
// The tree helpers walk the heap-ordered pseudo-LRU: node n has children 2n+1 / 2n+2.
package dcache_way_replacer_pkg;

    localparam int NSET   = 32;
    localparam int NWAY   = 8;
    localparam int IDX_W  = 5;
    localparam int WAY_W  = 3;
    localparam int PLRU_W = NWAY - 1;

    // Lowest-indexed empty way; only meaningful when at least one occ bit is clear.
    function automatic logic [WAY_W-1:0] find_first_zero(input logic [NWAY-1:0] occ);
        logic [WAY_W-1:0] res;
        res = '0;
        for (int i = NWAY - 1; i >= 0; i--) begin
            if (!occ[i]) begin
                res = WAY_W'(i);
            end
        end
        return res;
    endfunction

    function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] plru);
        logic [WAY_W-1:0] w;
        int               n;
        w = '0;
        n = 0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            w[WAY_W-1-lvl] = plru[n];
            n = 2 * n + 1 + int'(plru[n]);
        end
        return w;
    endfunction

    // Every node on the root->way path is made to point away from way.
    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] plru,
                                                     input logic [WAY_W-1:0]  way);
        logic [PLRU_W-1:0] res;
        int                n;
        res = plru;
        n   = 0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            res[n] = ~way[WAY_W-1-lvl];
            n = 2 * n + 1 + int'(way[WAY_W-1-lvl]);
        end
        return res;
    endfunction

endpackage

// File: rtl/dcache_way_replacer_dff_en.sv
// Enabled register with asynchronous active-low reset to a fixed value.
module dff_en #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dcache_way_replacer.sv
// Victim-way selector for the 32-set x 8-way dcache: per-set occupancy plus tree PLRU,
// with a combinational refill-way proposal for the set addressed by idx.
module dcache_way_replacer
    import dcache_way_replacer_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [IDX_W-1:0] idx,
    input  logic [WAY_W-1:0] way,
    input  logic             access,
    input  logic             invalid,
    output logic [WAY_W-1:0] rway_o
);

    logic [NWAY-1:0]   occ_q  [NSET];
    logic [NWAY-1:0]   occ_d  [NSET];
    logic [NSET-1:0]   occ_en;
    logic [PLRU_W-1:0] plru_q [NSET];
    logic [PLRU_W-1:0] plru_d [NSET];
    logic [NSET-1:0]   plru_en;
    logic [NWAY-1:0]   way_onehot;

    assign way_onehot = NWAY'(1) << way;

    genvar gi;
    generate
        for (gi = 0; gi < NSET; gi++) begin : g_set
            logic sel;
            assign sel = (idx == IDX_W'(gi));

            // access has priority: an access+invalid pair leaves the line occupied.
            assign occ_en[gi]  = sel & (access | invalid);
            assign occ_d[gi]   = access ? (occ_q[gi] | way_onehot) : (occ_q[gi] & ~way_onehot);
            assign plru_en[gi] = sel & access;
            assign plru_d[gi]  = plru_touch(plru_q[gi], way);

            dff_en #(.WIDTH(NWAY), .RESET_VAL('0)) u_occ (
                .clock (clock),
                .reset (reset),
                .en    (occ_en[gi]),
                .d     (occ_d[gi]),
                .q     (occ_q[gi])
            );

            dff_en #(.WIDTH(PLRU_W), .RESET_VAL('0)) u_plru (
                .clock (clock),
                .reset (reset),
                .en    (plru_en[gi]),
                .d     (plru_d[gi]),
                .q     (plru_q[gi])
            );
        end
    endgenerate

    logic [NWAY-1:0]   occ_cur;
    logic [PLRU_W-1:0] plru_cur;

    assign occ_cur  = occ_q[idx];
    assign plru_cur = plru_q[idx];

    // Fill empty ways first; fall back to the PLRU tree only once the set is full.
    always_comb begin
        rway_o = find_first_zero(occ_cur);
        if (&occ_cur) begin
            rway_o = plru_victim(plru_cur);
        end
    end

endmodule

// File: tb/tb_dcache_way_replacer.sv
// Directed, table-driven bench for dcache_way_replacer with hand-computed victims.
module tb_dcache_way_replacer;

    logic       clock;
    logic       reset;
    logic [4:0] idx;
    logic [2:0] way;
    logic       access;
    logic       invalid;
    logic [2:0] rway_o;

    int n_checks = 0;
    int n_pass   = 0;

    dcache_way_replacer dut (
        .clock   (clock),
        .reset   (reset),
        .idx     (idx),
        .way     (way),
        .access  (access),
        .invalid (invalid),
        .rway_o  (rway_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [4:0] idx;
        logic [2:0] way;
        logic       acc;
        logic       inv;
        logic [2:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int i, input int w, input int a, input int v, input int e,
                       input string nm);
        vec_t t;
        t.idx = 5'(i);
        t.way = 3'(w);
        t.acc = a[0];
        t.inv = v[0];
        t.exp = 3'(e);
        t.name = nm;
        vecs.push_back(t);
    endtask

    task automatic check(input string nm, input logic [2:0] exp);
        n_checks++;
        if (rway_o === exp) begin
            n_pass++;
            $display("ok   %s idx=%0d rway_o=%0d", nm, idx, rway_o);
        end else begin
            $display("FAIL %s idx=%0d rway_o=%0d expected=%0d", nm, idx, rway_o, exp);
        end
    endtask

    task automatic sweep_zero(input string nm);
        for (int i = 0; i < 32; i++) begin
            idx = 5'(i);
            #1;
            check(nm, 3'd0);
        end
    endtask

    initial begin
        reset   = 1'b0;
        idx     = '0;
        way     = '0;
        access  = 1'b0;
        invalid = 1'b0;

        // Test 2: fill set 3 in order, then full set falls back to PLRU.
        for (int w = 0; w < 8; w++) add(3, w, 1, 0, (w + 1) % 8, "fill");
        // Test 3
        add(3, 0, 1, 0, 4, "mru_w0");
        add(3, 4, 1, 0, 2, "mru_w4");
        // Test 4
        add(4, 0, 0, 0, 0, "idx4_pre");
        add(3, 6, 0, 1, 6, "inval_w6");
        add(3, 6, 1, 0, 2, "refill_w6");
        add(4, 0, 0, 0, 0, "idx4_post");
        // Test 5
        add(3, 5, 1, 1, 2, "acc_inv_w5");
        add(3, 0, 0, 0, 2, "hold");

        #12;
        reset = 1'b1;
        #1;
        sweep_zero("reset_sweep");

        @(negedge clock);
        foreach (vecs[k]) begin
            idx     = vecs[k].idx;
            way     = vecs[k].way;
            access  = vecs[k].acc;
            invalid = vecs[k].inv;
            @(posedge clock);
            #1;
            access  = 1'b0;
            invalid = 1'b0;
            check(vecs[k].name, vecs[k].exp);
        end

        // Test 6: async reset between edges while an access is pending.
        @(negedge clock);
        idx    = 5'd3;
        way    = 3'd2;
        access = 1'b1;
        #1;
        check("pre_async", 3'd2);
        reset = 1'b0;
        #1;
        check("async_clear", 3'd0);
        @(posedge clock);
        #1;
        check("reset_hold", 3'd0);
        @(negedge clock);
        access = 1'b0;
        reset  = 1'b1;
        #1;
        sweep_zero("post_reset_sweep");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout rway_o=%0d expected=finish", rway_o);
        $fatal(1, "timeout");
    end

endmodule
